// File: rtl/core_idu_dq_pkg.sv
// Shared decode definitions for the decode queue: RV32I opcodes, op_type encodings and
// the per-entry control record written by the decoder and read at the queue head.
package core_idu_dq_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [5:0] {
        OP_ILL    = 6'd0,
        OP_ALU    = 6'd1,
        OP_ALUI   = 6'd2,
        OP_LOAD   = 6'd3,
        OP_STORE  = 6'd4,
        OP_BRANCH = 6'd5,
        OP_JAL    = 6'd6,
        OP_JALR   = 6'd7,
        OP_LUI    = 6'd8,
        OP_AUIPC  = 6'd9,
        OP_SYS    = 6'd10
    } op_type_e;

    // Everything an entry needs except the XLEN-wide pc and immediate.
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] func3;
        logic       func7;
        logic [4:0] rs1_idx;
        logic [4:0] rs2_idx;
        logic [4:0] rd_idx;
        op_type_e   op_type;
    } dec_ctl_t;

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    endfunction

endpackage

// File: rtl/core_idu_dq_if.sv
// Fetch, scoreboard/GPR and dispatch signals of the decode queue.
// slave is the queue's own view; master is the surrounding pipeline (IFU, GPR, EXU, LSU).
interface core_idu_dq_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 3
);
    logic             flush;

    logic [XLEN-1:0]  idu_rx_pc;
    logic [31:0]      idu_rx_inst;
    logic             idu_rx_valid;
    logic             idu_rx_ready;

    logic [4:0]       idu_tx_rs1_idx;
    logic [4:0]       idu_tx_rs2_idx;
    logic [XLEN-1:0]  idu_rx_rs1;
    logic [XLEN-1:0]  idu_rx_rs2;
    logic             reg_rs_ready;

    logic             idu_tx_exu_valid;
    logic             idu_rx_exu_ready;
    logic             idu_tx_lsu_valid;
    logic             idu_rx_lsu_ready;

    logic [XLEN-1:0]  idu_tx_pc;
    logic [6:0]       idu_tx_opcode;
    logic [2:0]       idu_tx_func3;
    logic             idu_tx_func7;
    logic [XLEN-1:0]  idu_tx_rs1;
    logic [XLEN-1:0]  idu_tx_rs2;
    logic [4:0]       idu_tx_rd_idx;
    logic [5:0]       idu_tx_op_type;
    logic [XLEN-1:0]  idu_tx_imme;
    logic [CNT_W-1:0] idu_tx_count;

    modport slave (
        input  flush,
        input  idu_rx_pc, idu_rx_inst, idu_rx_valid,
        output idu_rx_ready,
        output idu_tx_rs1_idx, idu_tx_rs2_idx,
        input  idu_rx_rs1, idu_rx_rs2, reg_rs_ready,
        output idu_tx_exu_valid, idu_tx_lsu_valid,
        input  idu_rx_exu_ready, idu_rx_lsu_ready,
        output idu_tx_pc, idu_tx_opcode, idu_tx_func3, idu_tx_func7,
        output idu_tx_rs1, idu_tx_rs2, idu_tx_rd_idx, idu_tx_op_type, idu_tx_imme,
        output idu_tx_count
    );

    modport master (
        output flush,
        output idu_rx_pc, idu_rx_inst, idu_rx_valid,
        input  idu_rx_ready,
        input  idu_tx_rs1_idx, idu_tx_rs2_idx,
        output idu_rx_rs1, idu_rx_rs2, reg_rs_ready,
        input  idu_tx_exu_valid, idu_tx_lsu_valid,
        output idu_rx_exu_ready, idu_rx_lsu_ready,
        input  idu_tx_pc, idu_tx_opcode, idu_tx_func3, idu_tx_func7,
        input  idu_tx_rs1, idu_tx_rs2, idu_tx_rd_idx, idu_tx_op_type, idu_tx_imme,
        input  idu_tx_count
    );

endinterface

// File: rtl/core_idu_dq_dec.sv
// RV32I field decoder on the queue write side: splits a fetched instruction into the
// stored control record and a sign-extended immediate.
module core_idu_dq_dec
    import core_idu_dq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output dec_ctl_t        ctl,
    output logic [XLEN-1:0] imme
);

    logic signed [31:0] imm32;

    // NOTE: every output gets a default before the case, so no path can leave one unassigned and infer a latch.
    always_comb begin
        ctl         = '0;
        imm32       = '0;
        ctl.opcode  = inst[6:0];
        ctl.func3   = inst[14:12];
        ctl.func7   = inst[30];
        ctl.rs1_idx = inst[19:15];
        ctl.rs2_idx = inst[24:20];
        ctl.rd_idx  = inst[11:7];
        ctl.op_type = OP_ILL;

        case (inst[6:0])
            OPC_OP: begin
                ctl.op_type = OP_ALU;
            end
            OPC_OPIMM: begin
                ctl.op_type = OP_ALUI;
                imm32       = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_LOAD: begin
                ctl.op_type = OP_LOAD;
                imm32       = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_JALR: begin
                ctl.op_type = OP_JALR;
                imm32       = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_SYSTEM: begin
                ctl.op_type = OP_SYS;
                imm32       = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_STORE: begin
                ctl.op_type = OP_STORE;
                imm32       = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                ctl.op_type = OP_BRANCH;
                imm32       = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LUI: begin
                ctl.op_type = OP_LUI;
                imm32       = {inst[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                ctl.op_type = OP_AUIPC;
                imm32       = {inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                ctl.op_type = OP_JAL;
                imm32       = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: begin
                ctl.op_type = OP_ILL;
            end
        endcase
    end

    // Signed source, so the size cast sign-extends when XLEN is wider than 32.
    assign imme = XLEN'(imm32);

endmodule

// File: rtl/core_idu_dq.sv
// Decode queue between IFU and EXU/LSU: decodes on entry, buffers DEPTH entries and
// dispatches the scoreboard-cleared head on the EXU or LSU channel; flush empties it.
module core_idu_dq
    import core_idu_dq_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int XLEN  = 32,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    core_idu_dq_if.slave bus
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    dec_ctl_t         ctl_mem [DEPTH];
    logic [XLEN-1:0]  pc_mem  [DEPTH];
    logic [XLEN-1:0]  imm_mem [DEPTH];

    dec_ctl_t         dec_ctl;
    logic [XLEN-1:0]  dec_imme;
    dec_ctl_t         head_ctl;

    logic             full;
    logic             empty;
    logic             enq;
    logic             deq;
    logic             hv;
    logic             head_is_mem;

    core_idu_dq_dec #(.XLEN(XLEN)) u_dec (
        .inst (bus.idu_rx_inst),
        .ctl  (dec_ctl),
        .imme (dec_imme)
    );

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

    // Ready looks only at occupancy; a same-cycle dequeue does not free a slot early.
    assign enq = bus.idu_rx_valid && !full && !bus.flush;

    assign head_ctl    = ctl_mem[rd_ptr];
    assign head_is_mem = is_mem_op(head_ctl.opcode);
    assign hv          = !empty && bus.reg_rs_ready && !bus.flush;

    assign deq = (hv && !head_is_mem && bus.idu_rx_exu_ready) ||
                 (hv &&  head_is_mem && bus.idu_rx_lsu_ready);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: entry storage is deliberately left unreset; pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            ctl_mem[wr_ptr] <= dec_ctl;
            pc_mem[wr_ptr]  <= bus.idu_rx_pc;
            imm_mem[wr_ptr] <= dec_imme;
        end
    end

    assign bus.idu_rx_ready     = !full;

    assign bus.idu_tx_exu_valid = hv && !head_is_mem;
    assign bus.idu_tx_lsu_valid = hv &&  head_is_mem;

    assign bus.idu_tx_rs1_idx   = head_ctl.rs1_idx;
    assign bus.idu_tx_rs2_idx   = head_ctl.rs2_idx;
    assign bus.idu_tx_rs1       = bus.idu_rx_rs1;
    assign bus.idu_tx_rs2       = bus.idu_rx_rs2;

    assign bus.idu_tx_pc        = pc_mem[rd_ptr];
    assign bus.idu_tx_imme      = imm_mem[rd_ptr];
    assign bus.idu_tx_opcode    = head_ctl.opcode;
    assign bus.idu_tx_func3     = head_ctl.func3;
    assign bus.idu_tx_func7     = head_ctl.func7;
    assign bus.idu_tx_rd_idx    = head_ctl.rd_idx;
    assign bus.idu_tx_op_type   = head_ctl.op_type;

    assign bus.idu_tx_count     = count;

endmodule
